// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and field definitions for the CPU datapath
//
// Purpose: opcode/OpExt constants, sequencer state encoding, instruction
//          field positions and a legality helper shared by the sequencer.
// Ports:   none (package).
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_MOV   = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;

  // LUI exists only as an immediate form, so R-type callers pass allow_lui=0.
  function automatic logic op_is_legal(input logic [3:0] op, input logic allow_lui);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV: op_is_legal = 1'b1;
      OP_LUI:  op_is_legal = allow_lui;
      default: op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_ext.sv
// rtl/imm_ext.sv - immediate extension for I-type instructions
//
// Purpose: build the 16-bit ALU immediate from Imm[7:0] and the opcode.
// Ports:   i_imm8   in  8   raw immediate field
//          i_opcode in  4   instruction opcode
//          o_imm    out 16  extended immediate (0 for R-type / unknown)
module imm_ext
  import cpu_pkg::*;
(
  input  logic [7:0]  i_imm8,
  input  logic [3:0]  i_opcode,
  output logic [15:0] o_imm
);

  always_comb begin
    o_imm = 16'h0000;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_CMP:         o_imm = {{8{i_imm8[7]}}, i_imm8};
      OP_AND, OP_OR, OP_XOR, OP_MOV:  o_imm = {8'h00, i_imm8};
      OP_LUI:                         o_imm = {i_imm8, 8'h00};
      default:                        o_imm = 16'h0000;
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - register-file access sequencer for the 16x16 datapath
//
// Purpose: accept one instruction, decode it into register-file read
//          addresses and ALU controls, then pulse a one-hot write enable.
// Ports:   clk          in  1      system clock
//          reset        in  1      synchronous active-low reset
//          instr        in  16     instruction word
//          instr_valid  in  1      instr presented
//          instr_ready  out 1      high only in IDLE
//          raddrA       out 4      read address A (Rdest)
//          raddrB       out 4      read address B (Rsrc, 0 for immediates)
//          alu_op       out 4      ALU operation
//          use_imm      out 1      ALU B operand is imm
//          imm          out 16     extended immediate
//          flags_en     out 1      ALU flag load, EXEC only
//          regEnable    out NREGS  one-hot write enable, WB only
//          illegal      out 1      undecodable instruction, EXEC only
module regfile_ctrl
  import cpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [3:0]       raddrA,
  output logic [3:0]       raddrB,
  output logic [3:0]       alu_op,
  output logic             use_imm,
  output logic [15:0]      imm,
  output logic             flags_en,
  output logic [NREGS-1:0] regEnable,
  output logic             illegal
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr;
  logic [15:0] r_imm;
  logic [15:0] w_imm_raw;
  logic        w_accept;
  logic        w_rtype;
  logic [3:0]  w_op;
  logic        w_legal;
  logic        w_flag_op;
  logic        w_has_wb;

  // Extension runs on the incoming word so the registered imm is ready in DECODE.
  imm_ext u_imm_ext (
    .i_imm8   (instr[IMM_MSB:0]),
    .i_opcode (instr[OPC_MSB:OPC_LSB]),
    .o_imm    (w_imm_raw)
  );

  assign w_accept  = (r_state == S_IDLE) && instr_valid;
  assign w_rtype   = (r_instr[OPC_MSB:OPC_LSB] == OP_RTYPE);
  assign w_op      = w_rtype ? r_instr[EXT_MSB:EXT_LSB] : r_instr[OPC_MSB:OPC_LSB];
  assign w_legal   = op_is_legal(w_op, !w_rtype);
  assign w_flag_op = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_CMP);
  assign w_has_wb  = w_legal && (w_op != OP_CMP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_instr <= 16'h0000;
      r_imm   <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_instr <= instr;
        r_imm   <= w_imm_raw;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    flags_en  = 1'b0;
    illegal   = 1'b0;
    regEnable = '0;
    case (r_state)
      S_IDLE:   if (instr_valid) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        flags_en = w_legal && w_flag_op;
        illegal  = !w_legal;
        w_next   = w_has_wb ? S_WB : S_IDLE;
      end
      S_WB: begin
        regEnable = {{(NREGS-1){1'b0}}, 1'b1} << r_instr[RD_MSB:RD_LSB];
        w_next    = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Decode fields come straight from the latch, so they hold until the next accept.
  assign instr_ready = (r_state == S_IDLE);
  assign raddrA      = r_instr[RD_MSB:RD_LSB];
  assign raddrB      = w_rtype ? r_instr[RS_MSB:RS_LSB] : 4'h0;
  assign alu_op      = w_op;
  assign use_imm     = !w_rtype;
  assign imm         = r_imm;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - directed self-checking bench for regfile_ctrl
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  raddrA;
  logic [3:0]  raddrB;
  logic [3:0]  alu_op;
  logic        use_imm;
  logic [15:0] imm;
  logic        flags_en;
  logic [15:0] regEnable;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] s_regen [1:4];
  logic        s_ready [1:4];
  logic        s_flags [1:4];
  logic        s_ill   [1:4];
  logic [3:0]  s_ra, s_rb, s_op;
  logic        s_ui;
  logic [15:0] s_imm;

  always #5 clk = ~clk;

  regfile_ctrl #(.NREGS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .raddrA      (raddrA),
    .raddrB      (raddrB),
    .alu_op      (alu_op),
    .use_imm     (use_imm),
    .imm         (imm),
    .flags_en    (flags_en),
    .regEnable   (regEnable),
    .illegal     (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  instr_ready, 1);
    chk({tag, "_regen"},  regEnable, 0);
    chk({tag, "_flags"},  flags_en, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_raddrA"}, raddrA, 0);
    chk({tag, "_raddrB"}, raddrB, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_use_imm"}, use_imm, 0);
    chk({tag, "_imm"},    imm, 0);
  endtask

  // Present one word for exactly one accepting edge; returns just after it.
  task automatic issue(input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", instr_ready, 1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'h0000;
  endtask

  // Four negedge samples after the accept edge: DECODE, EXEC, WB/IDLE, ...
  task automatic capture();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      s_regen[k] = regEnable;
      s_ready[k] = instr_ready;
      s_flags[k] = flags_en;
      s_ill[k]   = illegal;
      if (k == 1) begin
        s_ra = raddrA; s_rb = raddrB; s_op = alu_op; s_ui = use_imm; s_imm = imm;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;

    // ADDI R3,#0xFF
    issue(16'h53FF);
    capture();
    chk("addi_imm", s_imm, 16'hFFFF);
    chk("addi_use_imm", s_ui, 1);
    chk("addi_alu_op", s_op, 4'h5);
    chk("addi_raddrA", s_ra, 3);
    chk("addi_raddrB", s_rb, 0);
    chk("addi_flags_exec", s_flags[2], 1);
    chk("addi_flags_dec", s_flags[1], 0);
    chk("addi_regen_dec", s_regen[1], 0);
    chk("addi_regen_exec", s_regen[2], 0);
    chk("addi_regen_wb", s_regen[3], 16'h0008);
    chk("addi_regen_after", s_regen[4], 0);
    chk("addi_ready1", s_ready[1], 0);
    chk("addi_ready2", s_ready[2], 0);
    chk("addi_ready3", s_ready[3], 0);
    chk("addi_ready4", s_ready[4], 1);

    // ADD R2,R7
    issue(16'h0257);
    capture();
    chk("add_raddrA", s_ra, 2);
    chk("add_raddrB", s_rb, 7);
    chk("add_use_imm", s_ui, 0);
    chk("add_imm", s_imm, 0);
    chk("add_alu_op", s_op, 4'h5);
    chk("add_regen_exec", s_regen[2], 0);
    chk("add_regen_wb", s_regen[3], 16'h0004);
    chk("add_regen_after", s_regen[4], 0);

    // CMP R1,R4
    issue(16'h01B4);
    capture();
    chk("cmp_alu_op", s_op, 4'hB);
    chk("cmp_flags_exec", s_flags[2], 1);
    for (int k = 1; k <= 4; k++) chk("cmp_regen", s_regen[k], 0);
    chk("cmp_ready2", s_ready[2], 0);
    chk("cmp_ready3", s_ready[3], 1);

    // LUI R15,#0xA5
    issue(16'hFFA5);
    capture();
    chk("lui_imm", s_imm, 16'hA500);
    chk("lui_alu_op", s_op, 4'hF);
    chk("lui_use_imm", s_ui, 1);
    chk("lui_flags", s_flags[2], 0);
    chk("lui_regen_wb", s_regen[3], 16'h8000);

    // Illegal R-type, OpExt 0000
    issue(16'h0E04);
    capture();
    chk("ill_pulse_dec", s_ill[1], 0);
    chk("ill_pulse_exec", s_ill[2], 1);
    chk("ill_pulse_after", s_ill[3], 0);
    chk("ill_flags", s_flags[2], 0);
    for (int k = 1; k <= 4; k++) chk("ill_regen", s_regen[k], 0);
    chk("ill_ready2", s_ready[2], 0);
    chk("ill_ready3", s_ready[3], 1);

    // MOVI R5,#0x12 with reset asserted in WB
    issue(16'hD512);
    @(negedge clk);
    chk("movi_imm", imm, 16'h0012);
    chk("movi_use_imm", use_imm, 1);
    @(negedge clk);
    @(negedge clk);
    chk("movi_regen_wb", regEnable, 16'h0020);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("wb_reset");
    reset = 1'b1;
    @(negedge clk);
    chk("wb_reset_regen_next", regEnable, 0);
    chk("wb_reset_ready_next", instr_ready, 1);

    // instr_valid held high with instr changing outside IDLE
    instr = 16'h53FF;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = 16'h0257;
    @(negedge clk);
    chk("hold_dec_raddrA", raddrA, 3);
    chk("hold_dec_imm", imm, 16'hFFFF);
    chk("hold_dec_ready", instr_ready, 0);
    instr = 16'h0E04;
    @(negedge clk);
    chk("hold_exec_alu_op", alu_op, 4'h5);
    chk("hold_exec_illegal", illegal, 0);
    chk("hold_exec_raddrA", raddrA, 3);
    instr = 16'h0257;
    @(negedge clk);
    chk("hold_wb_regen", regEnable, 16'h0008);
    chk("hold_wb_use_imm", use_imm, 1);
    @(negedge clk);
    chk("hold_idle_ready", instr_ready, 1);
    chk("hold_idle_raddrA", raddrA, 3);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("hold_next_raddrA", raddrA, 2);
    chk("hold_next_raddrB", raddrB, 7);
    chk("hold_next_use_imm", use_imm, 0);
    chk("hold_next_ready", instr_ready, 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
